// File: rtl/alu_fault_engine.sv
// Fault-injecting ALU: valid/ready single-op datapath with a trigger/duration fault window
// and selectable opcode-stuck, bit-flip, stuck-at and result-delay faults.
module alu_fault_engine #(
   parameter int WIDTH     = 32,
   parameter int CNT_W     = 8,
   parameter int DELAY_MAX = 7
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_in_valid,
   output logic                           o_in_ready,
   input  logic [WIDTH-1:0]               i_a,
   input  logic [WIDTH-1:0]               i_b,
   input  logic [2:0]                     i_alu_ctrl,
   input  logic                           i_cfg_arm,
   input  logic [2:0]                     i_cfg_mode,
   input  logic [2:0]                     i_cfg_op,
   input  logic [$clog2(WIDTH)-1:0]       i_cfg_bit,
   input  logic [$clog2(DELAY_MAX+1)-1:0] i_cfg_delay,
   input  logic [CNT_W-1:0]               i_cfg_trigger,
   input  logic [CNT_W-1:0]               i_cfg_duration,
   output logic                           o_out_valid,
   input  logic                           i_out_ready,
   output logic [WIDTH-1:0]               o_result,
   output logic                           o_zero,
   output logic                           o_negative,
   output logic                           o_carry,
   output logic                           o_overflow,
   output logic                           o_fault_applied,
   output logic [1:0]                     o_fault_state
);
   // state      | meaning
   // S_DISARMED | no fault window, waiting for arm
   // S_COUNT    | counting clean ops until the trigger op
   // S_ACTIVE   | every accepted op is faulted
   // S_EXPIRED  | window closed, waiting for re-arm
   localparam int DW  = $clog2(DELAY_MAX+1);
   localparam int MSB = WIDTH-1;

   typedef enum logic [1:0] {
      S_DISARMED = 2'b00,
      S_COUNT    = 2'b01,
      S_ACTIVE   = 2'b10,
      S_EXPIRED  = 2'b11
   } fault_state_t;

   fault_state_t     r_state, w_state_nxt;
   logic [CNT_W-1:0] r_trig_cnt, w_trig_nxt, r_dur_cnt, w_dur_nxt, w_dur_p1;
   logic             r_busy;
   logic [DW-1:0]    r_dly_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_zero, r_negative, r_carry, r_overflow, r_fault_applied;
   logic             w_accept, w_hit, w_fault;
   logic [2:0]       w_op;
   logic [WIDTH:0]   w_sum, w_diff;
   logic [WIDTH-1:0] w_res_raw, w_res;
   logic             w_carry, w_ovf;

   assign o_out_valid     = r_busy && (r_dly_cnt == '0);
   assign o_in_ready      = !i_rst && (!r_busy || (o_out_valid && i_out_ready));
   assign w_accept        = i_in_valid && o_in_ready;
   assign w_hit           = ((r_state == S_COUNT) && (r_trig_cnt == i_cfg_trigger)) ||
                            (r_state == S_ACTIVE);
   assign w_fault         = w_hit && (i_cfg_mode != 3'd0) && (i_cfg_mode <= 3'd5);
   assign w_dur_p1        = r_dur_cnt + CNT_W'(1);
   assign o_fault_state   = r_state;
   assign o_result        = r_result;
   assign o_zero          = r_zero;
   assign o_negative      = r_negative;
   assign o_carry         = r_carry;
   assign o_overflow      = r_overflow;
   assign o_fault_applied = r_fault_applied;

   // dur_cnt counts faulted ops already issued, so the window holds exactly cfg_duration ops
   always_comb begin
      w_state_nxt = r_state;
      w_trig_nxt  = r_trig_cnt;
      w_dur_nxt   = r_dur_cnt;
      if (w_accept) begin
         case (r_state)
            S_COUNT: begin
               if (r_trig_cnt == i_cfg_trigger) begin
                  w_dur_nxt   = CNT_W'(1);
                  w_state_nxt = (i_cfg_duration == CNT_W'(1)) ? S_EXPIRED : S_ACTIVE;
               end else begin
                  w_trig_nxt = r_trig_cnt + CNT_W'(1);
               end
            end
            S_ACTIVE: begin
               if ((i_cfg_duration != '0) && (w_dur_p1 == i_cfg_duration))
                  w_state_nxt = S_EXPIRED;
               else
                  w_dur_nxt = w_dur_p1;
            end
            default: ;
         endcase
      end
      if (i_cfg_arm) begin
         w_state_nxt = S_COUNT;
         w_trig_nxt  = '0;
         w_dur_nxt   = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_DISARMED;
         r_trig_cnt <= '0;
         r_dur_cnt  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_trig_cnt <= w_trig_nxt;
         r_dur_cnt  <= w_dur_nxt;
      end
   end

   assign w_op   = (w_fault && (i_cfg_mode == 3'd1)) ? i_cfg_op : i_alu_ctrl;
   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};

   always_comb begin
      w_res_raw = '0;
      w_carry   = 1'b0;
      w_ovf     = 1'b0;
      case (w_op)
         3'b000: w_res_raw = i_a & i_b;
         3'b001: w_res_raw = i_a | i_b;
         3'b010: begin
            w_res_raw = w_sum[MSB:0];
            w_carry   = w_sum[WIDTH];
            w_ovf     = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
         end
         3'b110: begin
            w_res_raw = w_diff[MSB:0];
            w_carry   = !w_diff[WIDTH];
            w_ovf     = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
         end
         3'b111: w_res_raw = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         3'b100: w_res_raw = ~(i_a | i_b);
         default: ;
      endcase
   end

   // bit faults touch only the result; carry/overflow stay those of the executed op
   always_comb begin
      w_res = w_res_raw;
      if (w_fault) begin
         case (i_cfg_mode)
            3'd2: w_res[i_cfg_bit] = ~w_res_raw[i_cfg_bit];
            3'd3: w_res[i_cfg_bit] = 1'b0;
            3'd4: w_res[i_cfg_bit] = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy          <= 1'b0;
         r_dly_cnt       <= '0;
         r_result        <= '0;
         r_zero          <= 1'b0;
         r_negative      <= 1'b0;
         r_carry         <= 1'b0;
         r_overflow      <= 1'b0;
         r_fault_applied <= 1'b0;
      end else if (w_accept) begin
         r_busy          <= 1'b1;
         r_dly_cnt       <= (w_fault && (i_cfg_mode == 3'd5)) ? i_cfg_delay : '0;
         r_result        <= w_res;
         r_zero          <= (w_res == '0);
         r_negative      <= w_res[MSB];
         r_carry         <= w_carry;
         r_overflow      <= w_ovf;
         r_fault_applied <= w_fault;
      end else if (o_out_valid && i_out_ready) begin
         r_busy <= 1'b0;
      end else if (r_dly_cnt != '0) begin
         r_dly_cnt <= r_dly_cnt - DW'(1);
      end
   end
endmodule

// File: tb/tb_alu_fault_engine.sv
// Bench for alu_fault_engine: transaction-level reference model checked every cycle,
// plus directed vectors with literal expectations (32-bit and 8-bit builds).
module tb_alu_fault_engine;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, cfg_arm, out_valid, out_ready;
   logic [31:0] a, b, result;
   logic [2:0]  alu_ctrl, cfg_mode, cfg_op, cfg_delay;
   logic [4:0]  cfg_bit;
   logic [7:0]  cfg_trigger, cfg_duration;
   logic        zero, negative, carry, overflow, fault_applied;
   logic [1:0]  fault_state;

   logic        in_valid8, in_ready8, cfg_arm8, out_valid8, out_ready8;
   logic [7:0]  a8, b8, result8, cfg_trigger8, cfg_duration8;
   logic [2:0]  alu_ctrl8, cfg_mode8, cfg_op8, cfg_bit8, cfg_delay8;
   logic        zero8, negative8, carry8, overflow8, fault_applied8;
   logic [1:0]  fault_state8;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   alu_fault_engine #(.WIDTH(32), .CNT_W(8), .DELAY_MAX(7)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_a(a), .i_b(b), .i_alu_ctrl(alu_ctrl), .i_cfg_arm(cfg_arm),
      .i_cfg_mode(cfg_mode), .i_cfg_op(cfg_op), .i_cfg_bit(cfg_bit),
      .i_cfg_delay(cfg_delay), .i_cfg_trigger(cfg_trigger), .i_cfg_duration(cfg_duration),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_result(result),
      .o_zero(zero), .o_negative(negative), .o_carry(carry), .o_overflow(overflow),
      .o_fault_applied(fault_applied), .o_fault_state(fault_state));

   alu_fault_engine #(.WIDTH(8), .CNT_W(8), .DELAY_MAX(7)) u_dut8 (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid8), .o_in_ready(in_ready8),
      .i_a(a8), .i_b(b8), .i_alu_ctrl(alu_ctrl8), .i_cfg_arm(cfg_arm8),
      .i_cfg_mode(cfg_mode8), .i_cfg_op(cfg_op8), .i_cfg_bit(cfg_bit8),
      .i_cfg_delay(cfg_delay8), .i_cfg_trigger(cfg_trigger8), .i_cfg_duration(cfg_duration8),
      .o_out_valid(out_valid8), .i_out_ready(out_ready8), .o_result(result8),
      .o_zero(zero8), .o_negative(negative8), .o_carry(carry8), .o_overflow(overflow8),
      .o_fault_applied(fault_applied8), .o_fault_state(fault_state8));

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          cyc = 0;
   bit          m_busy = 1'b0, m_armed = 1'b0;
   int          m_valid_at = 0, m_k = 0, m_trig = 0, m_dur = 0;
   logic [31:0] m_res = '0;
   logic        m_c = 1'b0, m_v = 1'b0, m_fa = 1'b0;

   function automatic void alu_ref(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output logic c, output logic v);
      longint sx, sy, ux, uy, s;
      longint lim;
      sx  = longint'($signed(x));
      sy  = longint'($signed(y));
      ux  = longint'({32'd0, x});
      uy  = longint'({32'd0, y});
      lim = 2147483647;
      r = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'b000: r = x & y;
         3'b001: r = x | y;
         3'b010: begin r = x + y; c = (ux + uy) >= 64'h1_0000_0000; s = sx + sy; v = (s > lim) || (s < -lim - 1); end
         3'b110: begin r = x - y; c = (ux >= uy); s = sx - sy; v = (s > lim) || (s < -lim - 1); end
         3'b111: r = (sx < sy) ? 32'd1 : 32'd0;
         3'b100: r = ~(x | y);
         default: r = '0;
      endcase
   endfunction

   function automatic int m_fstate();
      if (!m_armed) return 0;
      if (m_k <= m_trig) return 1;
      if (m_dur == 0 || m_k < m_trig + m_dur) return 2;
      return 3;
   endfunction

   always @(posedge clk) begin
      bit          acc, hs, hit, fa;
      logic [2:0]  op;
      logic [31:0] r;
      logic        c, v;
      if (rst) begin
         m_busy = 1'b0; m_armed = 1'b0; m_k = 0;
      end else begin
         hs  = m_busy && (cyc >= m_valid_at) && out_ready;
         acc = in_valid && (!m_busy || hs);
         if (hs) m_busy = 1'b0;
         if (acc) begin
            hit = m_armed && (m_k >= m_trig) && (m_dur == 0 || m_k < m_trig + m_dur);
            fa  = hit && (cfg_mode >= 3'd1) && (cfg_mode <= 3'd5);
            op  = (fa && cfg_mode == 3'd1) ? cfg_op : alu_ctrl;
            alu_ref(op, a, b, r, c, v);
            if (fa && cfg_mode == 3'd2) r[cfg_bit] = ~r[cfg_bit];
            if (fa && cfg_mode == 3'd3) r[cfg_bit] = 1'b0;
            if (fa && cfg_mode == 3'd4) r[cfg_bit] = 1'b1;
            m_res = r; m_c = c; m_v = v; m_fa = fa;
            m_busy = 1'b1;
            m_valid_at = cyc + 1 + ((fa && cfg_mode == 3'd5) ? int'(cfg_delay) : 0);
            if (m_armed) m_k++;
         end
         if (cfg_arm) begin
            m_armed = 1'b1; m_k = 0; m_trig = int'(cfg_trigger); m_dur = int'(cfg_duration);
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      bit e_valid;
      if (chk_en) begin
         e_valid = m_busy && (cyc >= m_valid_at);
         chk1("cmp_out_valid", out_valid, e_valid);
         chk1("cmp_in_ready", in_ready, !rst && (!m_busy || (e_valid && out_ready)));
         chk32("cmp_fault_state", 32'(fault_state), m_fstate());
         if (e_valid) begin
            chk32("cmp_result", result, m_res);
            chk1("cmp_zero", zero, m_res == '0);
            chk1("cmp_negative", negative, m_res[31]);
            chk1("cmp_carry", carry, m_c);
            chk1("cmp_overflow", overflow, m_v);
            chk1("cmp_fault_applied", fault_applied, m_fa);
         end
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {logic [2:0] op; logic [31:0] x; logic [31:0] y; logic [31:0] r; logic c; logic v;} vec_t;
   vec_t vecs[7] = '{
      '{3'b001, 32'h0F0F_0000, 32'h00F0_F0F0, 32'h0FFF_F0F0, 1'b0, 1'b0},
      '{3'b100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0},
      '{3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0},
      '{3'b110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0},
      '{3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1},
      '{3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1},
      '{3'b011, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0}};
   logic [31:0] t2_res[5] = '{32'd5, 32'd5, 32'd0, 32'd0, 32'd5};
   logic        t2_fa[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, output int n);
      bit got = 1'b0;
      a = x; b = y; alu_ctrl = op; in_valid = 1'b1; n = 0;
      while (!got && n < 40) begin
         @(negedge clk); n++; got = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!got) begin
         n_checks++; n_errors++;
         $display("FAIL send_timeout: in_ready low for %0d cycles, required high", n);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid && n < 40);
      if (!out_valid) begin
         n_checks++; n_errors++;
         $display("FAIL wait_valid_timeout: out_valid low for %0d cycles, required high", n);
      end
   endtask

   task automatic arm(input logic [2:0] mode, input logic [2:0] op, input logic [4:0] bitsel,
                      input logic [2:0] dly, input logic [7:0] trig, input logic [7:0] dur);
      cfg_mode = mode; cfg_op = op; cfg_bit = bitsel; cfg_delay = dly;
      cfg_trigger = trig; cfg_duration = dur;
      step(); cfg_arm = 1'b1;
      step(); cfg_arm = 1'b0;
   endtask

   task automatic send8_chk(input string name, input logic [2:0] op, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] exp_r, input logic exp_z);
      int n = 0;
      a8 = x; b8 = y; alu_ctrl8 = op; in_valid8 = 1'b1;
      do begin @(negedge clk); n++; end while (!in_ready8 && n < 40);
      @(posedge clk); #1; in_valid8 = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!out_valid8 && n < 40);
      chk1({name, "_valid"}, out_valid8, 1'b1);
      chk32({name, "_result"}, 32'(result8), 32'(exp_r));
      chk1({name, "_zero"}, zero8, exp_z);
      chk1({name, "_fa"}, fault_applied8, 1'b1);
      chk1({name, "_carry"}, carry8, 1'b0);
      step();
   endtask

   initial begin
      int n, nb;
      logic [31:0] held;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_ctrl = '0; cfg_arm = 1'b0;
      cfg_mode = '0; cfg_op = '0; cfg_bit = '0; cfg_delay = '0; cfg_trigger = '0; cfg_duration = '0;
      out_ready = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; alu_ctrl8 = '0; cfg_arm8 = 1'b0; cfg_mode8 = '0;
      cfg_op8 = '0; cfg_bit8 = '0; cfg_delay8 = '0; cfg_trigger8 = '0; cfg_duration8 = '0;
      out_ready8 = 1'b1;

      step(); chk_en = 1'b1;
      @(negedge clk);
      chk1("rst_in_ready", in_ready, 1'b0);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk32("rst_result", result, 32'h0);
      chk32("rst_fault_state", 32'(fault_state), 32'd0);
      step(); rst = 1'b0;
      @(negedge clk);
      chk1("post_rst_in_ready", in_ready, 1'b1);

      // unarmed ADD wrap
      step();
      send(3'b010, 32'hFFFF_FFFF, 32'h1, n);
      wait_valid(n);
      chk32("add_wrap_latency", n, 32'd1);
      chk32("add_wrap_result", result, 32'h0);
      chk1("add_wrap_zero", zero, 1'b1);
      chk1("add_wrap_carry", carry, 1'b1);
      chk1("add_wrap_ovf", overflow, 1'b0);
      chk1("add_wrap_fa", fault_applied, 1'b0);
      chk32("model_pin_add", m_res, 32'h0);
      step();

      foreach (vecs[i]) begin
         send(vecs[i].op, vecs[i].x, vecs[i].y, n);
         wait_valid(n);
         chk32($sformatf("vec%0d_result", i), result, vecs[i].r);
         chk1($sformatf("vec%0d_carry", i), carry, vecs[i].c);
         chk1($sformatf("vec%0d_ovf", i), overflow, vecs[i].v);
         step();
      end

      // opcode-stuck window: trigger 2, duration 2
      arm(3'd1, 3'b000, 5'd0, 3'd0, 8'd2, 8'd2);
      for (int i = 0; i < 5; i++) begin
         send(3'b110, 32'd9, 32'd4, n);
         wait_valid(n);
         chk32($sformatf("stuck_op%0d_result", i), result, t2_res[i]);
         chk1($sformatf("stuck_op%0d_fa", i), fault_applied, t2_fa[i]);
         if (i == 2) chk1("model_pin_stuck_fa", m_fa, 1'b1);
         if (i == 4) chk32("stuck_end_state", 32'(fault_state), 32'd3);
         step();
      end

      // bit-flip, single op window
      arm(3'd2, 3'b000, 5'd31, 3'd0, 8'd0, 8'd1);
      send(3'b010, 32'd1, 32'd1, n);
      wait_valid(n);
      chk32("flip_result", result, 32'h8000_0002);
      chk1("flip_negative", negative, 1'b1);
      chk1("flip_carry", carry, 1'b0);
      chk1("flip_fa", fault_applied, 1'b1);
      step();
      send(3'b010, 32'd1, 32'd1, n);
      wait_valid(n);
      chk32("flip_after_result", result, 32'h2);
      chk1("flip_after_fa", fault_applied, 1'b0);
      step();

      // delay mode, permanent window, back-to-back then stalled consumer
      arm(3'd5, 3'b000, 5'd0, 3'd3, 8'd0, 8'd0);
      send(3'b010, 32'd3, 32'd4, n);
      send(3'b110, 32'd20, 32'd5, nb);
      chk32("delay_a_latency", nb, 32'd4);
      out_ready = 1'b0;
      wait_valid(n);
      chk32("delay_b_latency", n, 32'd4);
      chk32("delay_b_result", result, 32'd15);
      chk1("delay_b_fa", fault_applied, 1'b1);
      held = result;
      repeat (2) begin
         @(negedge clk);
         chk1("stall_valid", out_valid, 1'b1);
         chk32("stall_result", result, held);
         chk1("stall_in_ready", in_ready, 1'b0);
      end
      step(); out_ready = 1'b1;
      step();

      // 8-bit build, stuck-at-1 on bit 0
      cfg_mode8 = 3'd4; cfg_bit8 = 3'd0; cfg_trigger8 = 8'd0; cfg_duration8 = 8'd0;
      step(); cfg_arm8 = 1'b1;
      step(); cfg_arm8 = 1'b0;
      send8_chk("w8_slt", 3'b111, 8'h80, 8'h01, 8'h01, 1'b0);
      send8_chk("w8_and", 3'b000, 8'h0F, 8'hF0, 8'h01, 1'b0);

      // reset in the middle of a delayed op
      arm(3'd5, 3'b000, 5'd0, 3'd5, 8'd0, 8'd0);
      send(3'b010, 32'd2, 32'd3, n);
      rst = 1'b1;
      @(negedge clk);
      chk1("midrst_in_ready", in_ready, 1'b0);
      step(); rst = 1'b0;
      @(negedge clk);
      chk1("after_rst_in_ready", in_ready, 1'b1);
      chk1("after_rst_valid", out_valid, 1'b0);
      chk32("after_rst_state", 32'(fault_state), 32'd0);
      chk32("after_rst_result", result, 32'h0);
      chk1("after_rst_fa", fault_applied, 1'b0);
      repeat (6) begin
         @(negedge clk);
         chk1("after_rst_no_valid", out_valid, 1'b0);
      end
      step();
      send(3'b010, 32'd2, 32'd3, n);
      wait_valid(n);
      chk32("post_rst_latency", n, 32'd1);
      chk32("post_rst_result", result, 32'd5);
      chk1("post_rst_fa", fault_applied, 1'b0);
      step();
      repeat (2) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
